// File: rtl/decode_control_if.sv
// decode_control_if
//   Groups the decode-stage pipeline signals shared between the fetch/execute
//   stages (master side) and the decode controller (slave side).
//
//   Signals (direction as seen by the decode controller):
//     IR1wire_out    in   8  fetch-stage instruction ([3:0] op, [5:4] Rx, [7:6] Ry)
//     IR1Valid       in   1  IR1wire_out carries a real instruction
//     IR3wire_out    in   8  execute-stage instruction, same layout
//     BranchResolved in   1  execute finished a BR-class instruction (pulse)
//     IR2wire_out    out  8  decode-stage instruction register
//     IR2Load        out  1  IR2 captures at this edge
//     IR3Load        out  1  execute stage captures at this edge
//     IR3NopSel      out  1  execute stage captures NOP instead of IR2
//     RegReadX       out  2  register-file read address X (IR2 Rx)
//     RegReadY       out  2  register-file read address Y (IR2 Ry)
//     DecodeStall    out  1  fetch holds IR1 and PC
//     BranchPending  out  1  branch in flight downstream
//     StallCount     out  8  saturating stall-cycle counter
//                            (present only with DECODE_STALL_CNT_EN defined)
interface decode_control_if;
  logic [7:0] IR1wire_out;
  logic       IR1Valid;
  logic [7:0] IR3wire_out;
  logic       BranchResolved;
  logic [7:0] IR2wire_out;
  logic       IR2Load;
  logic       IR3Load;
  logic       IR3NopSel;
  logic [1:0] RegReadX;
  logic [1:0] RegReadY;
  logic       DecodeStall;
  logic       BranchPending;
`ifdef DECODE_STALL_CNT_EN
  logic [7:0] StallCount;

  modport master (
    output IR1wire_out, IR1Valid, IR3wire_out, BranchResolved,
    input  IR2wire_out, IR2Load, IR3Load, IR3NopSel, RegReadX, RegReadY,
           DecodeStall, BranchPending, StallCount
  );

  modport slave (
    input  IR1wire_out, IR1Valid, IR3wire_out, BranchResolved,
    output IR2wire_out, IR2Load, IR3Load, IR3NopSel, RegReadX, RegReadY,
           DecodeStall, BranchPending, StallCount
  );
`else
  modport master (
    output IR1wire_out, IR1Valid, IR3wire_out, BranchResolved,
    input  IR2wire_out, IR2Load, IR3Load, IR3NopSel, RegReadX, RegReadY,
           DecodeStall, BranchPending
  );

  modport slave (
    input  IR1wire_out, IR1Valid, IR3wire_out, BranchResolved,
    output IR2wire_out, IR2Load, IR3Load, IR3NopSel, RegReadX, RegReadY,
           DecodeStall, BranchPending
  );
`endif
endinterface

// File: rtl/decode_control.sv
// decode_control
//   Decode-stage controller of a 3-stage pipeline. Owns IR2, inserts one
//   bubble per load-use pair, and blocks decode while a branch is in flight
//   (BRWAIT) until execute reports BranchResolved.
//
//   Ports:
//     clock  in  single clock, rising edge
//     reset  in  synchronous active-high reset
//     bus    decode_control_if.slave (see rtl/decode_control_if.sv)
//
//   Optional feature: define DECODE_STALL_CNT_EN to add the 8-bit saturating
//   StallCount output counting cycles with DecodeStall=1.
module decode_control (
  input  logic               clock,
  input  logic               reset,
  decode_control_if.slave    bus
);

  localparam logic [3:0] OP_LOAD   = 4'b0000;
  localparam logic [3:0] OP_BR     = 4'b0001;
  localparam logic [7:0] NOP_INSTR = 8'h0A;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    BRWAIT = 1'b1
  } state_t;

  state_t     state_reg;
  logic [7:0] ir2_reg;
  logic       ir2_valid_reg;
  logic       branch_pending_reg;
  logic       hazard;

  // Load-use hazard: the LOAD in execute writes a register that the valid
  // instruction in decode is about to read.
  assign hazard = (state_reg == RUN) && ir2_valid_reg &&
                  (bus.IR3wire_out[3:0] == OP_LOAD) &&
                  ((bus.IR3wire_out[5:4] == ir2_reg[5:4]) ||
                   (bus.IR3wire_out[5:4] == ir2_reg[7:6]));

  always_comb begin
    bus.IR2Load     = 1'b1;
    bus.IR3Load     = 1'b1;
    bus.IR3NopSel   = ~ir2_valid_reg;
    bus.DecodeStall = 1'b0;
    case (state_reg)
      RUN: begin
        if (hazard) begin
          bus.IR2Load     = 1'b0;
          bus.IR3NopSel   = 1'b1;
          bus.DecodeStall = 1'b1;
        end
      end
      BRWAIT: begin
        bus.IR3NopSel   = 1'b1;
        bus.DecodeStall = 1'b1;
      end
      default: begin
        bus.IR3NopSel   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg          <= RUN;
      ir2_reg            <= NOP_INSTR;
      ir2_valid_reg      <= 1'b0;
      branch_pending_reg <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (!hazard) begin
            ir2_reg       <= bus.IR1Valid ? bus.IR1wire_out : NOP_INSTR;
            // A NOP is never a valid instruction, even if fetch flags it.
            ir2_valid_reg <= bus.IR1Valid && (bus.IR1wire_out != NOP_INSTR);
            // The branch leaves for execute this edge; wait for it there.
            if (ir2_valid_reg && (ir2_reg[3:0] == OP_BR)) begin
              state_reg          <= BRWAIT;
              branch_pending_reg <= 1'b1;
            end
          end
        end
        BRWAIT: begin
          ir2_reg       <= NOP_INSTR;
          ir2_valid_reg <= 1'b0;
          if (bus.BranchResolved) begin
            state_reg          <= RUN;
            branch_pending_reg <= 1'b0;
          end
        end
        default: begin
          state_reg          <= RUN;
          branch_pending_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.IR2wire_out   = ir2_reg;
  assign bus.RegReadX      = ir2_reg[5:4];
  assign bus.RegReadY      = ir2_reg[7:6];
  assign bus.BranchPending = branch_pending_reg;

`ifdef DECODE_STALL_CNT_EN
  logic [7:0] stall_count_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count_reg <= 8'd0;
    end else if (bus.DecodeStall && (stall_count_reg != 8'hFF)) begin
      stall_count_reg <= stall_count_reg + 8'd1;
    end
  end

  assign bus.StallCount = stall_count_reg;
`endif

endmodule

// File: doc/decode_control.md
DECODE_CONTROL -- requirements
Module: decode_control

Interface
REQ-001 clock  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset; sampled on rising edge of clock only.
REQ-003 IR1wire_out  input  8  fetch-stage instruction: [3:0] opcode, [5:4] Rx, [7:6] Ry.
REQ-004 IR1Valid  input  1  IR1wire_out holds a valid instruction this cycle.
REQ-005 IR3wire_out  input  8  execute-stage instruction, same field layout.
REQ-006 BranchResolved  input  1  one-cycle pulse from execute when a BR-class instruction completes.
REQ-007 IR2wire_out  output  8  decode-stage instruction register, owned by this block.
REQ-008 IR2Load  output  1  IR2 captured at this edge.
REQ-009 IR3Load  output  1  execute stage captures at this edge.
REQ-010 IR3NopSel  output  1  execute stage captures NOP instead of IR2wire_out.
REQ-011 RegReadX  output  2  equals IR2wire_out[5:4], combinational.
REQ-012 RegReadY  output  2  equals IR2wire_out[7:6], combinational.
REQ-013 DecodeStall  output  1  fetch holds IR1 and PC this cycle.
REQ-014 BranchPending  output  1  BR-class instruction unresolved downstream.

Function
REQ-015 Encodings: LOAD opcode 4'b0000; BR-class opcode 4'b0001; NOP instruction 8'h0A.
REQ-016 Internal IR2Valid bit qualifies IR2wire_out; NOP in IR2 always has IR2Valid=0.
REQ-017 States: RUN, BRWAIT; IR2Load, IR3Load, IR3NopSel, DecodeStall are combinational from state, IR2 and inputs.
REQ-018 hazard = state RUN & IR2Valid & IR3wire_out[3:0]==LOAD & (IR3wire_out[5:4]==IR2wire_out[5:4] | IR3wire_out[5:4]==IR2wire_out[7:6]).
REQ-019 RUN, no hazard: IR2Load=1; IR2 <= IR1Valid ? IR1wire_out : NOP; IR2Valid <= IR1Valid; IR3Load=1; IR3NopSel = ~IR2Valid; DecodeStall=0.
REQ-020 RUN, hazard: IR2Load=0, IR2 holds; IR3Load=1, IR3NopSel=1; DecodeStall=1; exactly one bubble per load-use pair (IR3 is NOP next cycle).
REQ-021 RUN -> BRWAIT when IR2Valid, IR2 opcode BR-class and no hazard (instruction passes to IR3 that edge).
REQ-022 BRWAIT: IR2 <= NOP, IR2Valid <= 0, IR2Load=1, IR3Load=1, IR3NopSel=1, DecodeStall=1, BranchPending=1.
REQ-023 BRWAIT -> RUN on the cycle after BranchResolved=1; first RUN cycle accepts IR1 normally.
REQ-024 BranchResolved in RUN ignored; hazard and BR-class in IR2 together: hazard first, transition next cycle.
REQ-025 BranchPending registered: 1 exactly while state is BRWAIT.

Reset
REQ-026 On reset: state RUN, IR2wire_out=8'h0A, IR2Valid=0, BranchPending=0; resulting IR3NopSel=1, DecodeStall=0.
REQ-027 Reset during BRWAIT or hazard abandons it; no stale stall next cycle; reset overrides all inputs.

Configuration
REQ-028 Macro DECODE_STALL_CNT_EN defined: output StallCount (8-bit) increments each cycle DecodeStall=1, saturates at 255, reset to 0.
REQ-029 Macro DECODE_STALL_CNT_EN undefined: port StallCount and counter absent; all other behaviour identical.

Verification
REQ-030 Reset, IR1Valid=0 for 3 cycles -> IR2wire_out=8'h0A, IR3NopSel=1, DecodeStall=0, BranchPending=0.
REQ-031 IR1=8'h62 valid -> next cycle IR2wire_out=8'h62, RegReadX=2'b10, RegReadY=2'b01, IR3NopSel=0.
REQ-032 IR2=8'h62, IR3=8'h20 (LOAD Rx=2) -> DecodeStall=1, IR3NopSel=1, IR2 held one cycle, then advances.
REQ-033 IR2=8'h01 (BR) -> BRWAIT, BranchPending=1, bubbles; BranchResolved pulse after 4 cycles -> RUN next cycle.
REQ-034 Reset asserted in BRWAIT -> next cycle RUN, BranchPending=0, IR2=8'h0A.
REQ-035 DECODE_STALL_CNT_EN defined, 300 stall cycles -> StallCount=255.
